// File: rtl/invader_fleet.sv
`default_nettype none
// ============================================================================
//  Module   : invader_fleet
//  Purpose  : Marching invader formation with bullet hit removal and
//             cleared / landed status for game control.
//  Revision : 1.0 - initial release
// ============================================================================
module invader_fleet #(
    parameter int          STEP_DIV   = 600000,
    parameter logic [19:0] INIT_ARRAY = 20'b0010_1010_1010_1010_1010,
    parameter logic [4:0]  INIT_LINE  = 5'd4,
    parameter logic [4:0]  LAND_LINE  = 5'd26
) (
    input  logic        dclk,
    input  logic        clr,
    input  logic        start,
    input  logic        enable,
    input  logic [4:0]  bulletX,
    input  logic [4:0]  bulletY,
    input  logic        bulletFlying,
    output logic [19:0] invArray,
    output logic [4:0]  invLine,
    output logic        hit,
    output logic [4:0]  alive,
    output logic        cleared,
    output logic        landed
);

    localparam int                 c_CNT_W   = $clog2(STEP_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STEP_DIV - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_MARCH   = 2'd1;
    localparam logic [1:0] c_ST_LANDED  = 2'd2;
    localparam logic [1:0] c_ST_CLEARED = 2'd3;

    localparam logic c_DIR_RIGHT = 1'b0;
    localparam logic c_DIR_LEFT  = 1'b1;

    function automatic logic [4:0] f_popcount(input logic [19:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 20; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    logic [1:0]         r_state;
    logic [19:0]        r_array;
    logic [4:0]         r_line;
    logic               r_dir;
    logic [c_CNT_W-1:0] r_count;
    logic               r_hit;
    logic [4:0]         r_alive;
    logic               r_cleared;
    logic               r_landed;

    logic [19:0]        w_hit_mask;
    logic               w_hit_now;
    logic [19:0]        w_post;
    logic               w_step;
    logic [1:0]         w_nxt_state;
    logic [19:0]        w_nxt_array;
    logic [4:0]         w_nxt_line;
    logic               w_nxt_dir;
    logic [c_CNT_W-1:0] w_nxt_count;
    logic               w_nxt_hit;

    always_comb begin
        w_hit_mask  = '0;
        w_hit_now   = 1'b0;
        w_step      = 1'b0;
        w_nxt_state = r_state;
        w_nxt_line  = r_line;
        w_nxt_dir   = r_dir;
        w_nxt_count = r_count;
        w_nxt_hit   = 1'b0;

        // A 20-bit mask shifted by an out-of-range column naturally becomes 0
        if (r_state == c_ST_MARCH && bulletFlying && bulletX < 5'd20 && bulletY == r_line)
            w_hit_mask = 20'd1 << bulletX;
        w_hit_now   = |(r_array & w_hit_mask);
        w_post      = r_array & ~w_hit_mask;
        w_nxt_array = w_post;
        w_nxt_hit   = w_hit_now;

        if (r_state == c_ST_MARCH && enable) begin
            if (r_count == c_CNT_MAX) begin
                w_nxt_count = '0;
                w_step      = 1'b1;
            end else begin
                w_nxt_count = r_count + 1'b1;
            end
        end

        if (w_step) begin
            if (r_dir == c_DIR_RIGHT) begin
                if (w_post[19]) begin
                    w_nxt_line = r_line + 5'd1;
                    w_nxt_dir  = c_DIR_LEFT;
                end else begin
                    w_nxt_array = w_post << 1;
                end
            end else begin
                if (w_post[0]) begin
                    w_nxt_line = r_line + 5'd1;
                    w_nxt_dir  = c_DIR_RIGHT;
                end else begin
                    w_nxt_array = w_post >> 1;
                end
            end
        end

        if (r_state == c_ST_MARCH) begin
            if (w_nxt_array == 20'd0)
                w_nxt_state = c_ST_CLEARED;
            else if (w_nxt_line == LAND_LINE)
                w_nxt_state = c_ST_LANDED;
        end

        // Start overrides any simultaneous hit or step
        if (start) begin
            w_nxt_state = c_ST_MARCH;
            w_nxt_array = INIT_ARRAY;
            w_nxt_line  = INIT_LINE;
            w_nxt_dir   = c_DIR_RIGHT;
            w_nxt_count = '0;
            w_nxt_hit   = 1'b0;
        end
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            r_state   <= c_ST_IDLE;
            r_array   <= INIT_ARRAY;
            r_line    <= INIT_LINE;
            r_dir     <= c_DIR_RIGHT;
            r_count   <= '0;
            r_hit     <= 1'b0;
            r_alive   <= f_popcount(INIT_ARRAY);
            r_cleared <= 1'b0;
            r_landed  <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_array   <= w_nxt_array;
            r_line    <= w_nxt_line;
            r_dir     <= w_nxt_dir;
            r_count   <= w_nxt_count;
            r_hit     <= w_nxt_hit;
            r_alive   <= f_popcount(w_nxt_array);
            r_cleared <= (w_nxt_state == c_ST_CLEARED);
            r_landed  <= (w_nxt_state == c_ST_LANDED);
        end
    end

    assign invArray = r_array;
    assign invLine  = r_line;
    assign hit      = r_hit;
    assign alive    = r_alive;
    assign cleared  = r_cleared;
    assign landed   = r_landed;

endmodule
`default_nettype wire
